// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/exec control FSM that drives the ALU control fields,
// latches ALU flags into the PSR and resolves conditional branches against it.
module alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_req,
  output logic [15:0] instr_addr,
  input  logic        instr_ack,
  input  logic [15:0] instr_data,
  output logic [3:0]  alu_oper,
  output logic [3:0]  alu_func,
  output logic [3:0]  alu_cond,
  input  logic [4:0]  alu_flags,
  output logic        imm_sel,
  output logic [15:0] imm,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [4:0]  psr,
  output logic [15:0] pc,
  output logic        halted
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  state_t      state_q;
  logic [15:0] ir_q, pc_q, pc_d, disp;
  logic [4:0]  psr_q;
  logic [3:0]  op, d, x, s;
  logic        is_r, is_i, is_b, wr, base, taken;
  assign {op, d, x, s} = ir_q;
  assign is_r = op == 4'h0;
  assign is_i = op != 4'h0 && op <= 4'hB;
  assign is_b = op == 4'hC;
  assign wr   = is_r | is_i;
  assign disp = {{8{ir_q[7]}}, ir_q[7:0]};
  // Conditions come in true/complement pairs; from code A up the even entry is the complement.
  always_comb begin
    case (d[3:1])
      3'd0:    base = psr_q[1];
      3'd1:    base = psr_q[4];
      3'd2:    base = psr_q[3];
      3'd3:    base = psr_q[0];
      3'd4:    base = psr_q[2];
      3'd5:    base = psr_q[3] | psr_q[1];
      3'd6:    base = psr_q[0] | psr_q[1];
      default: base = 1'b0;
    endcase
  end
  assign taken = base ^ d[0] ^ (d[3:1] >= 3'd5);
  assign pc_d  = pc_q + 16'd1 + ((is_b && taken) ? disp : 16'd0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      case (state_q)
        FETCH:   if (instr_ack) begin
                   ir_q    <= instr_data;
                   state_q <= DECODE;
                 end
        DECODE:  state_q <= op == 4'hF ? HALT : EXEC;
        EXEC:    begin
                   pc_q    <= pc_d;
                   if (wr) psr_q <= alu_flags;
                   state_q <= FETCH;
                 end
        default: state_q <= HALT;
      endcase
    end
  end
  // Request is gated by reset so it drops the moment reset_n falls.
  assign instr_req  = reset_n && state_q == FETCH;
  assign instr_addr = pc_q;
  assign alu_oper   = is_i ? op : 4'h0;
  assign alu_func   = is_r ? x : 4'h0;
  assign alu_cond   = is_b ? d : 4'h0;
  assign imm_sel    = is_i;
  assign imm        = is_i ? disp : 16'h0000;
  assign rf_raddr_a = wr ? d : 4'h0;
  assign rf_raddr_b = is_r ? s : 4'h0;
  assign rf_we      = state_q == EXEC && wr;
  assign rf_waddr   = rf_we ? d : 4'h0;
  assign psr        = psr_q;
  assign pc         = pc_q;
  assign halted     = state_q == HALT;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed instruction stream checked every cycle against an
// instruction-level model of the sequencer, plus hand-computed literal expectations.
module tb_alu_sequencer;
  logic        clk = 0, reset_n = 0, instr_ack = 0;
  logic [15:0] instr_data = 0;
  logic [4:0]  alu_flags = 0;
  logic        instr_req, imm_sel, rf_we, halted;
  logic [15:0] instr_addr, imm, pc;
  logic [3:0]  alu_oper, alu_func, alu_cond, rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [4:0]  psr;
  int checks = 0, failures = 0;

  alu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data), .alu_oper(alu_oper),
    .alu_func(alu_func), .alu_cond(alu_cond), .alu_flags(alu_flags),
    .imm_sel(imm_sel), .imm(imm), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .psr(psr), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Branch conditions as a truth table indexed by cond, built from flags {C,L,F,Z,N}.
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] p);
    logic [15:0] t;
    logic C, L, F, Z, N;
    {C, L, F, Z, N} = p;
    t = {1'b0, 1'b1, N | Z, !N & !Z, L | Z, !L & !Z, !F, F,
         !N, N, !L, L, !C, C, !Z, Z};
    return t[c];
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] ir, input logic [15:0] p,
                                          input logic [4:0] f);
    int n;
    n = int'(p) + 1;
    if (ir[15:12] == 4'hC && cond_true(ir[11:8], f)) n += int'($signed(ir[7:0]));
    return 16'(n);
  endfunction

  // Model: phase 0 fetch, 1 decode, 2 exec, 3 halted.
  int phase = 0;
  logic [15:0] m_pc = 0, m_ir = 0;
  logic [4:0]  m_psr = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 0; m_pc <= 16'h0000; m_ir <= 0; m_psr <= 0;
    end else if (phase == 0) begin
      if (instr_ack) begin m_ir <= instr_data; phase <= 1; end
    end else if (phase == 1) begin
      phase <= (m_ir[15:12] == 4'hF) ? 3 : 2;
    end else if (phase == 2) begin
      phase <= 0;
      m_pc  <= next_pc(m_ir, m_pc, m_psr);
      if (m_ir[15:12] <= 4'hB) m_psr <= alu_flags;
    end
  end

  always @(negedge clk) begin
    logic exp_we;
    exp_we = phase == 2 && m_ir[15:12] <= 4'hB;
    chk("instr_req", instr_req, reset_n && phase == 0);
    chk("instr_addr", instr_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("psr", psr, m_psr);
    chk("halted", halted, phase == 3);
    chk("rf_we", rf_we, exp_we);
    if (exp_we) chk("rf_waddr", rf_waddr, m_ir[11:8]);
    if (phase == 1 || phase == 2) begin
      if (m_ir[15:12] == 4'h0) begin
        chk("alu_oper", alu_oper, 0);
        chk("alu_func", alu_func, m_ir[7:4]);
        chk("raddr_a", rf_raddr_a, m_ir[11:8]);
        chk("raddr_b", rf_raddr_b, m_ir[3:0]);
        chk("imm_sel", imm_sel, 0);
      end else if (m_ir[15:12] <= 4'hB) begin
        chk("alu_oper", alu_oper, m_ir[15:12]);
        chk("alu_func", alu_func, 0);
        chk("raddr_a", rf_raddr_a, m_ir[11:8]);
        chk("imm", imm, 16'($signed(m_ir[7:0])));
        chk("imm_sel", imm_sel, 1);
      end else if (m_ir[15:12] == 4'hC) begin
        chk("alu_cond", alu_cond, m_ir[11:8]);
      end
    end
  end

  int req_n = 0, we_n = 0;
  logic [3:0]  l_waddr = 0, l_oper = 0, l_func = 0, l_ra = 0, l_rb = 0;
  logic [15:0] l_imm = 0;
  always @(negedge clk) begin
    if (instr_req) req_n <= req_n + 1;
    if (rf_we) begin
      we_n <= we_n + 1; l_waddr <= rf_waddr; l_oper <= alu_oper; l_func <= alu_func;
      l_ra <= rf_raddr_a; l_rb <= rf_raddr_b; l_imm <= imm;
    end
  end

  // mode: 0 normal, 1 stray ack during DECODE, 2 reset during EXEC, 3 HALT (stops in DECODE)
  task automatic run(input logic [15:0] w, input int waits, input logic [4:0] fl, input int mode);
    alu_flags = fl;
    repeat (waits) begin @(posedge clk); #1; end
    instr_ack = 1; instr_data = w;
    @(posedge clk); #1;
    instr_ack = mode == 1; instr_data = 16'hF000;
    if (mode == 3) begin instr_ack = 0; return; end
    @(posedge clk); #1;
    instr_ack = 0;
    if (mode == 2) begin
      reset_n = 0;
      repeat (3) begin @(posedge clk); #1; end
      reset_n = 1;
      return;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int r0, w0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pc, 16'h0000);
    chk("reset psr", psr, 0);
    reset_n = 1;
    r0 = req_n; w0 = we_n;
    run(16'h0312, 2, 5'b00000, 0);
    chk("t1 req cycles", 16'(req_n - r0), 3);
    chk("t1 we pulses", 16'(we_n - w0), 1);
    chk("t1 waddr", l_waddr, 3);
    chk("t1 func", l_func, 1);
    chk("t1 raddr_a", l_ra, 3);
    chk("t1 raddr_b", l_rb, 2);
    chk("t1 pc", pc, 1);
    run(16'h54FE, 0, 5'b00010, 0);
    chk("t2 oper", l_oper, 5);
    chk("t2 imm", l_imm, 16'hFFFE);
    chk("t2 waddr", l_waddr, 4);
    chk("t2 psr", psr, 5'b00010);
    run(16'hCEFC, 1, 5'b11111, 0);
    chk("t4 uc pc", pc, 16'hFFFF);
    run(16'hD000, 0, 0, 0);
    run(16'hE000, 0, 0, 0);
    run(16'hD000, 0, 0, 0);
    chk("nop wrap pc", pc, 16'h0002);
    run(16'hCFFC, 0, 0, 0);
    chk("t4 nv pc", pc, 16'h0003);
    repeat (5) run(16'hD000, 0, 0, 0);
    w0 = we_n;
    run(16'hC005, 0, 0, 0);
    chk("t3 eq taken pc", pc, 16'd14);
    chk("t3 no we", 16'(we_n - w0), 0);
    run(16'h5100, 0, 5'b00000, 0);
    run(16'hCEF8, 0, 0, 0);
    chk("back to 8", pc, 16'd8);
    run(16'hC005, 0, 0, 0);
    chk("t3 eq not taken pc", pc, 16'd9);
    run(16'h0123, 0, 5'b10101, 1);
    chk("t6 stray ack psr", psr, 5'b10101);
    chk("t6 stray ack pc", pc, 16'd10);
    w0 = we_n;
    run(16'h0456, 0, 5'b11111, 2);
    chk("t6 reset no we", 16'(we_n - w0), 0);
    chk("t6 reset psr", psr, 0);
    chk("t6 reset pc", pc, 0);
    run(16'hD000, 0, 0, 0);
    run(16'hF000, 0, 0, 3);
    @(posedge clk); #1;
    r0 = req_n;
    repeat (20) @(posedge clk);
    #1;
    chk("t5 halted", halted, 1);
    chk("t5 no req", 16'(req_n - r0), 0);
    chk("t5 pc frozen", pc, 16'd1);
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk); #1;
    chk("t5 resume req", instr_req, 1);
    chk("t5 resume pc", pc, 0);
    chk("t5 not halted", halted, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
